// File: rtl/rule_cfg_writer.sv
// rule_cfg_writer: turns a stream of 32-bit config words (header + payload)
// into single-cycle rule-table write strobes with registered field values.
module rule_cfg_writer #(
    parameter int RULE_NUM         = 8,
    parameter int TYPE_NUM         = 2,
    parameter int TYPE_WIDTH       = 16,
    parameter int KEY_FILED_NUM    = 8,
    parameter int KEY_OFFSET_WIDTH = 6,
    parameter int HEAD_SHIFT_WIDTH = 6,
    parameter int META_SHIFT_WIDTH = 6
) (
    input  logic                                        i_clk,
    input  logic                                        i_rst,
    input  logic                                        i_cfg_valid,
    output logic                                        o_cfg_ready,
    input  logic [31:0]                                 i_cfg_data,
    output logic [RULE_NUM-1:0]                         o_rule_wren,
    output logic                                        o_typeRule_valid,
    output logic [TYPE_NUM*TYPE_WIDTH-1:0]              o_typeRule_typeData,
    output logic [TYPE_NUM*TYPE_WIDTH-1:0]              o_typeRule_typeMask,
    output logic [KEY_FILED_NUM*(KEY_OFFSET_WIDTH+1)-1:0] o_typeRule_keyOffset,
    output logic [KEY_FILED_NUM*KEY_OFFSET_WIDTH-1:0]   o_typeRule_keyMergeOffset,
    output logic [HEAD_SHIFT_WIDTH-1:0]                 o_typeRule_headShift,
    output logic [META_SHIFT_WIDTH-1:0]                 o_typeRule_metaShift,
    output logic                                        o_busy,
    output logic                                        o_done,
    output logic [7:0]                                  o_err_cnt,
    output logic [15:0]                                 o_wr_cnt
);
    localparam int TD_W = TYPE_NUM * TYPE_WIDTH;
    localparam int KO_W = KEY_FILED_NUM * (KEY_OFFSET_WIDTH + 1);
    localparam int KM_W = KEY_FILED_NUM * KEY_OFFSET_WIDTH;
    localparam int PB   = 2 * TD_W + KO_W + KM_W + HEAD_SHIFT_WIDTH + META_SHIFT_WIDTH;
    localparam int PW   = (PB + 31) / 32;
    localparam int CW   = (PW > 1) ? $clog2(PW) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PW - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;
    localparam logic [1:0] S_DRAIN  = 2'd3;

    localparam logic [3:0] OP_WRITE     = 4'd1;
    localparam logic [3:0] OP_CLEAR     = 4'd2;
    localparam logic [3:0] OP_CLEAR_ALL = 4'd3;

    logic [1:0]          state_q,   state_d;
    logic [CW-1:0]       cnt_q,     cnt_d;
    logic [PW*32-1:0]    payload_q, payload_d;
    logic [7:0]          idx_q,     idx_d;
    logic                hvld_q,    hvld_d;
    logic                ready_q,   ready_d;
    logic [RULE_NUM-1:0] wren_q,    wren_d;
    logic                done_q,    done_d;
    logic [7:0]          err_q,     err_d;
    logic [15:0]         wr_q,      wr_d;
    logic                fvld_q,    fvld_d;
    logic [PB-1:0]       fld_q,     fld_d;
    logic                accept;

    function automatic logic [RULE_NUM-1:0] idx_onehot(input logic [7:0] idx);
        logic [RULE_NUM-1:0] oh;
        for (int r = 0; r < RULE_NUM; r++) oh[r] = (int'(idx) == r);
        return oh;
    endfunction

    function automatic logic [7:0] err_inc(input logic [7:0] cnt);
        return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    endfunction

    // Next-state logic: header decode, payload assembly, and the commit cycle.
    // Strobe and field registers are loaded on the edge that enters COMMIT so
    // they are stable for the whole strobe cycle and then hold.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        payload_d = payload_q;
        idx_d     = idx_q;
        hvld_d    = hvld_q;
        wren_d    = '0;
        done_d    = 1'b0;
        err_d     = err_q;
        wr_d      = wr_q;
        fvld_d    = fvld_q;
        fld_d     = fld_q;
        accept    = i_cfg_valid && ready_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (i_cfg_data[31:28])
                        OP_WRITE: begin
                            idx_d   = i_cfg_data[23:16];
                            hvld_d  = i_cfg_data[0];
                            cnt_d   = '0;
                            state_d = (int'(i_cfg_data[23:16]) < RULE_NUM) ? S_LOAD : S_DRAIN;
                        end
                        OP_CLEAR, OP_CLEAR_ALL: begin
                            state_d = S_COMMIT;
                            wren_d  = (i_cfg_data[31:28] == OP_CLEAR_ALL) ? '1
                                                                         : idx_onehot(i_cfg_data[23:16]);
                            done_d  = 1'b1;
                            wr_d    = wr_q + 16'd1;
                            fvld_d  = 1'b0;
                            fld_d   = '0;
                        end
                        default: err_d = err_inc(err_q);
                    endcase
                end
            end
            S_LOAD: begin
                if (accept) begin
                    for (int k = 0; k < PW; k++)
                        if (cnt_q == CW'(k)) payload_d[k*32 +: 32] = i_cfg_data;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_COMMIT;
                        wren_d  = idx_onehot(idx_q);
                        done_d  = 1'b1;
                        wr_d    = wr_q + 16'd1;
                        fvld_d  = hvld_q;
                        fld_d   = payload_d[PB-1:0];
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (accept) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        err_d   = err_inc(err_q);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Ready is registered so it stays low through reset and rises on the
        // first edge after release; it drops only for the COMMIT cycle.
        ready_d = (state_d != S_COMMIT);
    end

    // State and output registers, cleared by asynchronous reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            payload_q <= '0;
            idx_q     <= '0;
            hvld_q    <= 1'b0;
            ready_q   <= 1'b0;
            wren_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= '0;
            wr_q      <= '0;
            fvld_q    <= 1'b0;
            fld_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            payload_q <= payload_d;
            idx_q     <= idx_d;
            hvld_q    <= hvld_d;
            ready_q   <= ready_d;
            wren_q    <= wren_d;
            done_q    <= done_d;
            err_q     <= err_d;
            wr_q      <= wr_d;
            fvld_q    <= fvld_d;
            fld_q     <= fld_d;
        end
    end

    assign o_cfg_ready               = ready_q;
    assign o_busy                    = (state_q != S_IDLE);
    assign o_rule_wren               = wren_q;
    assign o_done                    = done_q;
    assign o_err_cnt                 = err_q;
    assign o_wr_cnt                  = wr_q;
    assign o_typeRule_valid          = fvld_q;
    assign o_typeRule_typeData       = fld_q[0 +: TD_W];
    assign o_typeRule_typeMask       = fld_q[TD_W +: TD_W];
    assign o_typeRule_keyOffset      = fld_q[2*TD_W +: KO_W];
    assign o_typeRule_keyMergeOffset = fld_q[2*TD_W+KO_W +: KM_W];
    assign o_typeRule_headShift      = fld_q[2*TD_W+KO_W+KM_W +: HEAD_SHIFT_WIDTH];
    assign o_typeRule_metaShift      = fld_q[2*TD_W+KO_W+KM_W+HEAD_SHIFT_WIDTH +: META_SHIFT_WIDTH];

endmodule
